// File: rtl/wshb_pkg.sv
// Shared definitions for the Wishbone RAM slave.
// Holds the cycle-type / burst-type codes the slave decodes and the
// control FSM state encoding, so the bench and RTL agree on names.
package wshb_pkg;

  // Cycle type identifiers (cti)
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Burst type identifiers (bte); only linear bursts are honoured
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  // Control FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ACK   = 2'd2,
    BURST = 2'd3
  } wshb_state_e;

endpackage

// File: rtl/wshb_ram_sp.sv
// Single-port 32-bit RAM with synchronous read and per-byte write enables.
// Ports:
//   clk    - clock, all activity on the rising edge
//   addr   - word address (shared by read and write)
//   we     - write enable
//   be     - byte-lane enables, be[i] covers wdata[8*i+7:8*i]
//   wdata  - write data
//   rdata  - registered read data (old contents on a same-edge write)
// Contents are never cleared; there is deliberately no reset.
module wshb_ram_sp #(
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && be[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/wshb_ram_slave.sv
// Wishbone B4 RAM slave with programmable wait states and linear
// incrementing bursts.
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   cyc, stb, we      - bus cycle, strobe, write enable
//   adr               - byte address; word index is adr[ADDR_WIDTH+1:2]
//   sel               - byte-lane enables for writes
//   cti, bte          - cycle type / burst type
//   dat_ms, dat_sm    - write data in, read data out (0 when not acking)
//   ack               - transfer acknowledge
//   dbg_state         - current control FSM state, for observation only
// Handshake: a beat completes on a rising edge where ack=1; ack is only
// ever high while cyc&stb is high in the same cycle. The master holds
// its request until acked; dropping cyc or stb abandons the access.
module wshb_ram_slave
  import wshb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 17,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cyc,
  input  logic        stb,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [3:0]  sel,
  input  logic [2:0]  cti,
  input  logic [1:0]  bte,
  input  logic [31:0] dat_ms,
  output logic [31:0] dat_sm,
  output logic        ack,
  output wshb_state_e dbg_state
);

  localparam logic [2:0]            WS_LOAD  = 3'(WAIT_STATES);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  wshb_state_e           state;
  logic [2:0]            wait_cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [31:0]           ram_q;
  logic                  req;
  logic                  ack_flag;
  logic                  burst_go;
  logic                  burst_more;
  logic                  wr_en;
  logic                  unused_adr_bits;

  assign unused_adr_bits = ^{adr[31:ADDR_WIDTH+2], adr[1:0]};

  assign req        = cyc & stb;
  assign burst_go   = (cti == CTI_INCR) && (bte == BTE_LINEAR);
  assign burst_more = (cti == CTI_INCR);
  assign ack_flag   = (state == ACK) || (state == BURST);
  assign ack        = ack_flag & req;
  assign dat_sm     = ack ? ram_q : 32'h0;
  assign wr_en      = ack & we & ~rst;
  assign dbg_state  = state;

  // Address the RAM will hold during the next cycle. Reading it now makes
  // the synchronous read data line up with the following ack cycle,
  // including the zero-wait-state and back-to-back burst cases.
  always_comb begin
    addr_d = addr_q;
    unique case (state)
      IDLE:    if (req) addr_d = adr[ADDR_WIDTH+1:2];
      ACK:     if (req && burst_go) addr_d = addr_q + ADDR_ONE;
      BURST:   if (req && burst_more) addr_d = addr_q + ADDR_ONE;
      default: addr_d = addr_q;
    endcase
    if (rst) addr_d = '0;
  end

  // A write beat needs the current word; otherwise prefetch the next one.
  assign ram_addr = wr_en ? addr_q : addr_d;

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= 3'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            wait_cnt <= WS_LOAD;
            state    <= (WAIT_STATES == 0) ? ACK : WAIT;
          end
        end
        WAIT: begin
          if (!req) begin
            state    <= IDLE;
            wait_cnt <= 3'd0;
          end else if (wait_cnt <= 3'd1) begin
            state    <= ACK;
            wait_cnt <= 3'd0;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        ACK: begin
          state <= (req && burst_go) ? BURST : IDLE;
        end
        BURST: begin
          // End-of-burst, any non-incrementing cti, or a dropped request
          // all finish the burst.
          state <= (req && burst_more) ? BURST : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  wshb_ram_sp #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (wr_en),
    .be    (sel),
    .wdata (dat_ms),
    .rdata (ram_q)
  );

endmodule
